rr_arbiter3: RTL and testbench
==============================

# rr_arbiter3

Three-way round-robin arbiter that returns exclusive grants to the three request lines the lab's OR stage merges into a single "any request" signal. Requesters `a`, `b`, `c` (bits 0, 1, 2 of `req`) raise requests; the block picks one by rotating priority, holds its grant until release, and reports activity. It sits between the three requester blocks and a single shared resource, and provides a registered any-request flag for downstream logic.

## Interface
- `MAX_HOLD`, 15: maximum grant length in cycles when the timeout feature is compiled in; legal range 1–255.
- `clk`  in  1  single clock; all logic is on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `req`  in  3  request lines; bit0 = a, bit1 = b, bit2 = c; level-sensitive.
- `gnt`  out  3  one-hot grant or all-zero.
- `gnt_id`  out  2  index of the granted requester (0–2); 0 when `gnt` is 0.
- `busy`  out  1  high while any grant is held.
- `any_req`  out  1  registered OR of `req`.
- `tmo`  out  1  one-cycle pulse on forced release (timeout builds only).

## Operation
- FSM states: IDLE, GRANT.
- IDLE: if `req` != 0, pick the first set bit scanning from `last+1` modulo 3. Load `gnt`/`gnt_id`, set `last` to the winner, and go to GRANT. Otherwise stay in IDLE.
- GRANT: hold `gnt` while `req[gnt_id]` = 1. When it drops, clear `gnt` and go to IDLE.
- Every release passes through IDLE for one cycle, so grants are never back-to-back. The dead cycle is `gnt` = 0 and `busy` = 0.
- Requests from other lines during GRANT are ignored; they are arbitrated in the next IDLE cycle.
- Priority pointer `last` (2 bits, values 0–2, wraps 2→0) resets to 2, so requester 0 has first priority after reset.
- Priority examples: with `last` = 1, `req` = 3'b111 grants 2, then 0, then 1. A lone requester always wins, whatever `last` is.
- `any_req` is `|req` registered one cycle, independent of FSM state.
- Outputs in IDLE: `gnt` = 0, `gnt_id` = 0, `busy` = 0.
- Reset values: `gnt` = 0, `gnt_id` = 0, `busy` = 0, `any_req` = 0, `tmo` = 0, state = IDLE, `last` = 2, hold counter = 0.
- Reset asserted mid-grant: outputs return to reset values on that edge. No release pulse, and `tmo` is not asserted.

## Timing
- Request to grant: `req` sampled high at edge N in IDLE gives `gnt` valid after edge N; 1-cycle latency.
- Release: `req[gnt_id]` sampled low at edge M gives `gnt` = 0 after edge M. The earliest next grant appears after edge M+1.
- Minimum grant length: 1 cycle. A request that drops the same cycle it is granted still holds `gnt` for that one cycle.
- A one-cycle `req` pulse that arrives during another requester's grant is lost. Requesters must hold `req` until they see their `gnt`.
- All outputs are registered. There are no combinational paths from `req` to any output.

## Configuration
- `RR_ARB3_TIMEOUT_EN` defined:
  - An 8-bit hold counter clears on grant and increments each GRANT cycle.
  - When it reaches `MAX_HOLD` with the request still high, the grant is force-released: `gnt` goes to 0 and the FSM returns to IDLE.
  - `tmo` pulses high for exactly that release cycle.
  - `last` already points at the victim, so the victim gets lowest priority at the next arbitration.
  - If `req` drops on the same edge the count reaches `MAX_HOLD`, this is a normal release and `tmo` stays 0.
- Undefined: no counter; `tmo` is tied 0 and grants are unbounded.

## Structure
- Package `rr_arbiter3_pkg`:
  - `N_REQ` = 3
  - state enum type (IDLE, GRANT)
  - `req_id_t` (2-bit)
  - `LAST_RESET` = 2
- Sub-module `rr_pick3`: combinational. Takes `req` (3 bits) and `last` (2 bits) and returns the winner's index plus a valid flag. The top instantiates it once.

## Test plan
- Reset: hold `rst_n` = 0 for 3 cycles with `req` = 3'b111. All outputs stay 0; after release, the first grant is `gnt` = 3'b001, `gnt_id` = 0.
- Rotation: hold `req` = 3'b111 and have each owner drop for 1 cycle after 2 granted cycles. Grants go 0, 1, 2, 0, each separated by one `gnt` = 0 cycle.
- Lone requester: `req` = 3'b100 with `last` = 2. Grant goes to 2 one cycle later; `any_req` = 1 one cycle after `req`.
- Contention in GRANT: a owns the grant; b and c rise. No change until a drops, then one dead cycle, then the grant goes to b (`gnt` = 3'b010).
- Timeout (built with `RR_ARB3_TIMEOUT_EN`, `MAX_HOLD` = 4): a holds `req` = 1 forever, b requests. `gnt` = 3'b001 for 4 cycles, then `tmo` = 1 for one cycle, then `gnt` = 3'b010.
- Mid-grant reset: during c's grant, pulse `rst_n` low for 1 cycle. `gnt` = 0 and `tmo` = 0 on that edge, then requester 0 has first priority again.

Source files
------------

// File: rtl/rr_arbiter3_pkg.sv
// rtl/rr_arbiter3_pkg.sv - shared types, constants and helpers for the three-way round-robin arbiter
package rr_arbiter3_pkg;

    localparam int N_REQ = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    typedef logic [1:0] req_id_t;

    localparam req_id_t LAST_RESET = 2'd2;

    // Index 3 never occurs; it maps to 0 so the pointer cannot stick.
    function automatic req_id_t next_id(input req_id_t id);
        return (id >= 2'd2) ? 2'd0 : id + 2'd1;
    endfunction

    function automatic logic req_hit(input logic [N_REQ-1:0] req, input req_id_t id);
        case (id)
            2'd0:    return req[0];
            2'd1:    return req[1];
            2'd2:    return req[2];
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [N_REQ-1:0] onehot(input req_id_t id);
        case (id)
            2'd0:    return 3'b001;
            2'd1:    return 3'b010;
            2'd2:    return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/rr_arbiter3_if.sv
// rtl/rr_arbiter3_if.sv - request/grant bundle between the requesters and the arbiter
interface rr_arbiter3_if;
    import rr_arbiter3_pkg::*;

    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] gnt;
    req_id_t          gnt_id;
    logic             busy;
    logic             any_req;
    logic             tmo;

    modport master (output req, input gnt, gnt_id, busy, any_req, tmo);
    modport slave  (input req, output gnt, gnt_id, busy, any_req, tmo);
endinterface

// File: rtl/rr_pick3.sv
// rtl/rr_pick3.sv - combinational winner selection scanning from last+1 modulo 3
import rr_arbiter3_pkg::*;

module rr_pick3 (
    input  logic [N_REQ-1:0] req,
    input  req_id_t          last,
    output req_id_t          id,
    output logic             valid
);
    req_id_t cand0, cand1, cand2;

    assign cand0 = next_id(last);
    assign cand1 = next_id(cand0);
    assign cand2 = next_id(cand1);

    always_comb begin
        valid = 1'b1;
        id    = cand0;
        if (req_hit(req, cand0)) begin
            id = cand0;
        end else if (req_hit(req, cand1)) begin
            id = cand1;
        end else if (req_hit(req, cand2)) begin
            id = cand2;
        end else begin
            valid = 1'b0;
            id    = 2'd0;
        end
    end
endmodule

// File: rtl/rr_arbiter3.sv
// rtl/rr_arbiter3.sv - three-way round-robin arbiter; RR_ARB3_TIMEOUT_EN adds a MAX_HOLD forced release
import rr_arbiter3_pkg::*;

module rr_arbiter3 #(
    parameter int unsigned MAX_HOLD = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    rr_arbiter3_if.slave bus
);
    state_t           state_q, state_d;
    req_id_t          last_q, last_d;
    req_id_t          id_q, id_d;
    req_id_t          win_id;
    logic             win_valid;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic             busy_q, busy_d;
    logic             tmo_q, tmo_d;
    logic             any_q;
    logic             timeout_hit;

    rr_pick3 u_pick (
        .req   (bus.req),
        .last  (last_q),
        .id    (win_id),
        .valid (win_valid)
    );

`ifdef RR_ARB3_TIMEOUT_EN
    localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD);
    logic [7:0] cnt_q, cnt_d;

    // Fires on the GRANT cycle whose increment would reach the limit.
    assign timeout_hit = (cnt_q + 8'd1) == HOLD_LIMIT;

    always_comb begin
        cnt_d = 8'd0;
        if (state_q == GRANT) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    logic unused_max_hold;
    assign unused_max_hold = (MAX_HOLD != 0);
    assign timeout_hit     = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        id_d    = id_q;
        gnt_d   = gnt_q;
        busy_d  = busy_q;
        tmo_d   = 1'b0;
        case (state_q)
            IDLE: begin
                gnt_d  = '0;
                id_d   = 2'd0;
                busy_d = 1'b0;
                if (win_valid) begin
                    state_d = GRANT;
                    last_d  = win_id;
                    id_d    = win_id;
                    gnt_d   = onehot(win_id);
                    busy_d  = 1'b1;
                end
            end
            GRANT: begin
                // A dropped request takes precedence, so a coincident timeout is a normal release.
                if (!req_hit(bus.req, id_q) || timeout_hit) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    id_d    = 2'd0;
                    busy_d  = 1'b0;
                    tmo_d   = req_hit(bus.req, id_q);
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                id_d    = 2'd0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            last_q  <= LAST_RESET;
            id_q    <= 2'd0;
            gnt_q   <= '0;
            busy_q  <= 1'b0;
            tmo_q   <= 1'b0;
            any_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            id_q    <= id_d;
            gnt_q   <= gnt_d;
            busy_q  <= busy_d;
            tmo_q   <= tmo_d;
            any_q   <= |bus.req;
        end
    end

    assign bus.gnt     = gnt_q;
    assign bus.gnt_id  = id_q;
    assign bus.busy    = busy_q;
    assign bus.tmo     = tmo_q;
    assign bus.any_req = any_q;
endmodule

// File: tb/tb_rr_arbiter3.sv
// tb/tb_rr_arbiter3.sv - self-checking bench for rr_arbiter3 with a cycle scoreboard and grant-order queue
module tb_rr_arbiter3;
    localparam int HOLD = 4;
`ifdef RR_ARB3_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    typedef struct {
        logic [2:0] gnt;
        logic [1:0] id;
        logic       busy;
        logic       any;
        logic       tmo;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    rr_arbiter3_if bus ();

    rr_arbiter3 #(.MAX_HOLD(HOLD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int tmo_seen = 0;
    exp_t sbq[$];
    int ord_q[$];
    logic [2:0] prev_gnt = 3'b000;

    logic [2:0] m_gnt = 0;
    logic [1:0] m_id = 0;
    logic m_busy = 0, m_any = 0, m_tmo = 0;
    int m_last = 2;
    int m_cnt = 0;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step(input logic [2:0] r, input logic rn);
        int idx;
        bit found;
        if (!rn) begin
            m_gnt = 0; m_id = 0; m_busy = 0; m_tmo = 0; m_last = 2; m_cnt = 0;
        end else begin
            m_tmo = 0;
            if (!m_busy) begin
                found = 0;
                for (int k = 1; k <= 3; k++) begin
                    idx = (m_last + k) % 3;
                    if (!found && r[idx]) begin
                        found = 1;
                        m_id = 2'(idx);
                    end
                end
                if (found) begin
                    m_gnt = 3'b001 << m_id; m_last = int'(m_id); m_busy = 1; m_cnt = 0;
                end else begin
                    m_gnt = 0; m_id = 0;
                end
            end else begin
                m_cnt++;
                if (!r[m_id] || (TMO_EN && m_cnt == HOLD)) begin
                    m_tmo = r[m_id];
                    m_gnt = 0; m_id = 0; m_busy = 0;
                end
            end
        end
        m_any = rn ? |r : 1'b0;
    endtask

    task automatic step(input logic [2:0] r, input logic rn);
        exp_t e;
        bus.req = r;
        rst_n = rn;
        model_step(r, rn);
        e.gnt = m_gnt; e.id = m_id; e.busy = m_busy; e.any = m_any; e.tmo = m_tmo;
        sbq.push_back(e);
        @(posedge clk);
        #1;
        e = sbq.pop_front();
        chk("gnt", 8'(bus.gnt), 8'(e.gnt));
        chk("gnt_id", 8'(bus.gnt_id), 8'(e.id));
        chk("busy", 8'(bus.busy), 8'(e.busy));
        chk("any_req", 8'(bus.any_req), 8'(e.any));
        chk("tmo", 8'(bus.tmo), 8'(e.tmo));
        if (prev_gnt == 3'b000 && bus.gnt != 3'b000 && ord_q.size() != 0)
            chk("order", 8'(bus.gnt_id), 8'(ord_q.pop_front()));
        if (bus.tmo) tmo_seen++;
        prev_gnt = bus.gnt;
    endtask

    initial begin
        int ord[3];
        bus.req = 3'b000;
        ord = '{0, 1, 2};

        // reset held with all requests up, then rotation 0,1,2,0
        ord_q = '{0, 1, 2, 0};
        repeat (3) step(3'b111, 1'b0);
        step(3'b111, 1'b1);
        chk("first_gnt", 8'(bus.gnt), 8'h01);
        for (int i = 0; i < 3; i++) begin
            step(3'b111, 1'b1);
            step(3'b111 & ~(3'b001 << ord[i]), 1'b1);
            chk("dead_cycle", 8'(bus.gnt), 8'h00);
            step(3'b111, 1'b1);
        end
        step(3'b111, 1'b1);
        step(3'b000, 1'b1);
        step(3'b000, 1'b1);
        chk("rot_order_left", 8'(ord_q.size()), 8'h00);

        // lone requester c right after reset
        step(3'b000, 1'b0);
        step(3'b000, 1'b1);
        chk("any_req_low", 8'(bus.any_req), 8'h00);
        step(3'b100, 1'b1);
        chk("lone_gnt", 8'(bus.gnt), 8'h04);
        chk("lone_any", 8'(bus.any_req), 8'h01);
        step(3'b100, 1'b1);
        step(3'b000, 1'b1);
        step(3'b000, 1'b1);

        // contention while a owns the grant
        ord_q = '{0, 1};
        step(3'b001, 1'b1);
        repeat (3) step(3'b111, 1'b1);
        chk("hold_a", 8'(bus.gnt), 8'h01);
        step(3'b110, 1'b1);
        step(3'b110, 1'b1);
        chk("cont_gnt_b", 8'(bus.gnt), 8'h02);
        step(3'b000, 1'b1);
        step(3'b000, 1'b1);
        chk("cont_order_left", 8'(ord_q.size()), 8'h00);

        // a holds forever with b waiting
        tmo_seen = 0;
        repeat (6) step(3'b011, 1'b1);
        chk("tmo_gnt_after6", 8'(bus.gnt), TMO_EN ? 8'h02 : 8'h01);
        repeat (3) step(3'b011, 1'b1);
        chk("tmo_pulses", 8'(tmo_seen), TMO_EN ? 8'h01 : 8'h00);
        step(3'b000, 1'b1);
        step(3'b000, 1'b1);

        // reset in the middle of c's grant
        step(3'b100, 1'b1);
        step(3'b100, 1'b1);
        chk("c_granted", 8'(bus.gnt), 8'h04);
        step(3'b111, 1'b0);
        chk("rst_gnt", 8'(bus.gnt), 8'h00);
        chk("rst_tmo", 8'(bus.tmo), 8'h00);
        step(3'b111, 1'b1);
        chk("post_rst_gnt", 8'(bus.gnt), 8'h01);
        step(3'b000, 1'b1);
        step(3'b000, 1'b1);

        // random traffic against the model
        for (int i = 0; i < 300; i++) begin
            step(3'($urandom_range(0, 7)), ($urandom_range(0, 99) != 0));
        end
        chk("sb_empty", 8'(sbq.size()), 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
